// File: rtl/dino_jump.sv
// rtl/dino_jump.sv - dinosaur runner game state and pixel generator
// Physics advances on frame ticks; px is a pure function of scan address and state.
module dino_jump (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       fresh,
   input  logic       button_jump,
   input  logic [8:0] row_addr,
   input  logic [9:0] col_addr,
   output logic       px,
   output logic       game_status
);

   localparam logic [10:0]       OX_START   = 11'd600;
   localparam logic [10:0]       OX_REENTER = 11'd640;
   localparam logic [10:0]       OX_STEP    = 11'd4;
   localparam logic [7:0]        JUMP_H     = 8'd12;
   localparam logic signed [7:0] JUMP_V     = 8'sd11;
   localparam logic [9:0]        DINO_LEFT  = 10'd80;
   localparam logic [9:0]        DINO_RIGHT = 10'd99;

   logic [7:0]        h, h_nxt;
   logic signed [7:0] v, v_nxt;
   logic [10:0]       ox, ox_nxt;
   logic              over, over_nxt;

   logic [11:0]       ox_right;
   logic signed [9:0] hv;
   logic              on_ground;
   logic              hit;

   assign ox_right  = {1'b0, ox} + 12'd9;
   assign hv        = $signed({2'b00, h}) + $signed({{2{v[7]}}, v});
   assign on_ground = (h == 8'd0) && (v == 8'sd0);
   assign hit       = (ox <= 11'd99) && (ox_right >= 12'd80) && (h <= 8'd19);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         h    <= 8'd0;
         v    <= 8'sd0;
         ox   <= OX_START;
         over <= 1'b0;
      end else begin
         h    <= h_nxt;
         v    <= v_nxt;
         ox   <= ox_nxt;
         over <= over_nxt;
      end
   end

   // A collision freezes everything on the same tick; no movement is applied.
   always_comb begin
      h_nxt    = h;
      v_nxt    = v;
      ox_nxt   = ox;
      over_nxt = over;
      if (fresh && !over) begin
         if (hit) begin
            over_nxt = 1'b1;
         end else begin
            if (on_ground) begin
               if (button_jump) begin
                  h_nxt = JUMP_H;
                  v_nxt = JUMP_V;
               end
            end else if (hv <= 10'sd0) begin
               h_nxt = 8'd0;
               v_nxt = 8'sd0;
            end else begin
               h_nxt = hv[7:0];
               v_nxt = v - 8'sd1;
            end
            if (ox == 11'd0) ox_nxt = OX_REENTER;
            else             ox_nxt = ox - OX_STEP;
         end
      end
   end

   logic        visible;
   logic        ground_on;
   logic        dino_on;
   logic        obst_on;
   logic [9:0]  row_h;
   logic [11:0] col_w;

   // Dino spans rows (370-h)..(399-h); adding h to the row avoids underflow.
   assign row_h = {1'b0, row_addr} + {2'b00, h};
   assign col_w = {2'b00, col_addr};

   always_comb begin
      visible   = (row_addr < 9'd480) && (col_addr < 10'd640);
      ground_on = (row_addr == 9'd400) || (row_addr == 9'd401);
      dino_on   = (col_addr >= DINO_LEFT) && (col_addr <= DINO_RIGHT) &&
                  (row_h >= 10'd370) && (row_h <= 10'd399);
      obst_on   = (col_w >= {1'b0, ox}) && (col_w <= ox_right) &&
                  (row_addr >= 9'd380) && (row_addr <= 9'd399);
      px        = visible && (ground_on || dino_on || obst_on);
   end

   assign game_status = over;

endmodule

// File: tb/tb_dino_jump.sv
// tb/tb_dino_jump.sv - directed table-driven bench for dino_jump
module tb_dino_jump;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       fresh = 1'b0;
   logic       button_jump = 1'b0;
   logic [8:0] row_addr = 9'd0;
   logic [9:0] col_addr = 10'd0;
   logic       px;
   logic       game_status;

   int checks = 0;
   int failures = 0;

   dino_jump dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .fresh       (fresh),
      .button_jump (button_jump),
      .row_addr    (row_addr),
      .col_addr    (col_addr),
      .px          (px),
      .game_status (game_status)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string name;
      logic  rst;
      int    ticks;
      logic  btn;
      int    row;
      int    col;
      logic  exp_px;
      logic  exp_st;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
      end
   endtask

   task automatic probe(input string nm, input int row, input int col, input logic exp);
      row_addr = row[8:0];
      col_addr = col[9:0];
      #1;
      check(nm, px, exp);
   endtask

   task automatic tick(input logic btn);
      @(negedge CLK);
      fresh = 1'b1;
      button_jump = btn;
      @(negedge CLK);
      fresh = 1'b0;
      button_jump = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      fresh = 1'b1;
      button_jump = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      fresh = 1'b0;
      button_jump = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // reset / scroll / jump scenario
      vecs.push_back('{"rst_dino",      1'b1, 0,  1'b0, 385, 85,  1'b1, 1'b0});
      vecs.push_back('{"rst_above",     1'b0, 0,  1'b0, 300, 85,  1'b0, 1'b0});
      vecs.push_back('{"rst_ground",    1'b0, 0,  1'b0, 400, 10,  1'b1, 1'b0});
      vecs.push_back('{"rst_obst",      1'b0, 0,  1'b0, 390, 605, 1'b1, 1'b0});
      vecs.push_back('{"rst_obst_rt",   1'b0, 0,  1'b0, 390, 611, 1'b0, 1'b0});
      vecs.push_back('{"row_oob",       1'b0, 0,  1'b0, 500, 10,  1'b0, 1'b0});
      vecs.push_back('{"col_oob",       1'b0, 0,  1'b0, 400, 700, 1'b0, 1'b0});
      vecs.push_back('{"scroll_in",     1'b0, 1,  1'b0, 390, 596, 1'b1, 1'b0});
      vecs.push_back('{"scroll_out",    1'b0, 0,  1'b0, 390, 606, 1'b0, 1'b0});
      vecs.push_back('{"jump_top",      1'b0, 1,  1'b1, 365, 85,  1'b1, 1'b0});
      vecs.push_back('{"jump_bot",      1'b0, 0,  1'b0, 395, 85,  1'b0, 1'b0});
      vecs.push_back('{"peak_top",      1'b0, 12, 1'b1, 292, 85,  1'b1, 1'b0});
      vecs.push_back('{"peak_above",    1'b0, 0,  1'b0, 291, 85,  1'b0, 1'b0});
      vecs.push_back('{"peak_bot",      1'b0, 0,  1'b0, 321, 85,  1'b1, 1'b0});
      vecs.push_back('{"peak_below",    1'b0, 0,  1'b0, 322, 85,  1'b0, 1'b0});
      vecs.push_back('{"landed",        1'b0, 12, 1'b1, 385, 85,  1'b1, 1'b0});
      vecs.push_back('{"landed_above",  1'b0, 0,  1'b0, 369, 85,  1'b0, 1'b0});
      vecs.push_back('{"rejump_top",    1'b0, 1,  1'b1, 365, 85,  1'b1, 1'b0});
      vecs.push_back('{"rejump_bot",    1'b0, 0,  1'b0, 395, 85,  1'b0, 1'b0});
      // collision scenario
      vecs.push_back('{"pre_hit_in",    1'b1, 126, 1'b0, 385, 105, 1'b1, 1'b0});
      vecs.push_back('{"pre_hit_out",   1'b0, 0,   1'b0, 385, 106, 1'b0, 1'b0});
      vecs.push_back('{"hit",           1'b0, 1,   1'b0, 385, 105, 1'b1, 1'b1});
      vecs.push_back('{"frozen_rt",     1'b0, 5,   1'b0, 385, 105, 1'b1, 1'b1});
      vecs.push_back('{"frozen_104",    1'b0, 0,   1'b0, 385, 104, 1'b1, 1'b1});
      vecs.push_back('{"frozen_jump",   1'b0, 3,   1'b1, 385, 85,  1'b1, 1'b1});
      vecs.push_back('{"over_rst_old",  1'b1, 0,   1'b0, 385, 105, 1'b0, 1'b0});
      vecs.push_back('{"over_rst_new",  1'b0, 0,   1'b0, 390, 605, 1'b1, 1'b0});

      // reset held with fresh toggling
      @(negedge CLK);
      RESET = 1'b1;
      for (int i = 0; i < 6; i++) begin
         fresh = ~fresh;
         button_jump = i[0];
         @(negedge CLK);
      end
      RESET = 1'b0;
      fresh = 1'b0;
      button_jump = 1'b0;
      #1;
      check("init_status", game_status, 1'b0);
      probe("init_dino", 385, 85, 1'b1);
      probe("init_obst", 390, 605, 1'b1);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         for (int t = 0; t < vecs[i].ticks; t++) tick(vecs[i].btn);
         probe(vecs[i].name, vecs[i].row, vecs[i].col, vecs[i].exp_px);
         check({vecs[i].name, "_status"}, game_status, vecs[i].exp_st);
      end

      // freeze while fresh is low
      do_reset();
      tick(1'b0);
      repeat (50) @(negedge CLK);
      probe("freeze_in", 390, 596, 1'b1);
      probe("freeze_out", 390, 606, 1'b0);
      probe("freeze_dino", 369, 85, 1'b0);

      // reset mid-jump
      do_reset();
      tick(1'b1);
      repeat (5) tick(1'b0);
      probe("midjump_air", 385, 85, 1'b0);
      do_reset();
      probe("midjump_rst_dino", 385, 85, 1'b1);
      probe("midjump_rst_above", 369, 85, 1'b0);
      probe("midjump_rst_obst", 390, 605, 1'b1);

      // clearance: jump when ox=120, then wrap after ox=0
      do_reset();
      repeat (120) tick(1'b0);
      probe("clr_ox120_l", 390, 120, 1'b1);
      probe("clr_ox120_r", 390, 130, 1'b0);
      tick(1'b1);
      for (int t = 0; t < 29; t++) begin
         tick(1'b0);
         check("clr_status", game_status, 1'b0);
      end
      probe("wrap_ox0_l", 390, 0, 1'b1);
      probe("wrap_ox0_r", 390, 9, 1'b1);
      probe("wrap_ox0_out", 390, 10, 1'b0);
      probe("wrap_landed", 385, 85, 1'b1);
      tick(1'b0);
      probe("wrap_640_c0", 390, 0, 1'b0);
      probe("wrap_640_c639", 390, 639, 1'b0);
      tick(1'b0);
      probe("wrap_636_l", 390, 636, 1'b1);
      probe("wrap_636_clip", 390, 639, 1'b1);
      probe("wrap_636_before", 390, 635, 1'b0);
      check("wrap_status", game_status, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
